// File: rtl/dmd_pkg.sv
// Shared constants and loader state encoding for the DMD frame buffer.
// The screen generator reads port B using these same values.
package dmd_pkg;

    localparam int unsigned DMD_COLS       = 128;
    localparam int unsigned DMD_ROWS       = 16;
    localparam int unsigned FB_ADDR_W      = 13;
    localparam int unsigned FB_ADDR_STRIDE = 4;
    localparam int unsigned FB_PIX_W       = 4;
    localparam logic [7:0]  FB_SYNC_BYTE   = 8'hA5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2
    } ldr_state_e;

endpackage

// File: rtl/dmd_pix_addr_gen.sv
// Pixel index counter (clear / advance-by-two) and the strided BRAM
// addresses for the current even pixel and its odd neighbour.
module dmd_pix_addr_gen #(
    parameter int unsigned NPIX        = 2048,
    parameter int unsigned ADDR_W      = 13,
    parameter int unsigned ADDR_STRIDE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              adv,
    output logic [ADDR_W-1:0] addr_even_c,
    output logic [ADDR_W-1:0] addr_odd_c,
    output logic              last_pair_c
);

    localparam int unsigned CNT_W = (NPIX > 2) ? $clog2(NPIX) : 1;

    logic [CNT_W-1:0] pix_q;
    logic [CNT_W-1:0] pix_d;

    always_comb begin
        pix_d = pix_q;
        if (clr) begin
            pix_d = '0;
        end else if (adv) begin
            pix_d = pix_q + CNT_W'(2);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_q <= '0;
        end else begin
            pix_q <= pix_d;
        end
    end

    // Truncation to ADDR_W is the intended silent wrap.
    assign addr_even_c = ADDR_W'(32'(pix_q) * ADDR_STRIDE);
    assign addr_odd_c  = ADDR_W'((32'(pix_q) + 32'd1) * ADDR_STRIDE);
    assign last_pair_c = (32'(pix_q) == (NPIX - 32'd2));

endmodule

// File: rtl/dmd_frame_loader.sv
// Host byte stream to frame BRAM port A: waits for sync, then unpacks
// two 4-bit pixels per byte into consecutive strided writes.
module dmd_frame_loader
    import dmd_pkg::*;
#(
    parameter int unsigned COLS        = DMD_COLS,
    parameter int unsigned ROWS        = DMD_ROWS,
    parameter int unsigned ADDR_W      = FB_ADDR_W,
    parameter int unsigned ADDR_STRIDE = FB_ADDR_STRIDE,
    parameter logic [7:0]  SYNC_BYTE   = FB_SYNC_BYTE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic                wea,
    output logic [ADDR_W-1:0]   addra,
    output logic [FB_PIX_W-1:0] dina,
    output logic                busy,
    output logic                frame_done
);

    localparam int unsigned NPIX = COLS * ROWS;

    ldr_state_e          state_q, state_d;
    logic                s_ready_q, s_ready_d;
    logic                wea_q, wea_d;
    logic [ADDR_W-1:0]   addra_q, addra_d;
    logic [FB_PIX_W-1:0] dina_q, dina_d;
    logic [FB_PIX_W-1:0] nib_q, nib_d;
    logic                done_q, done_d;

    logic                xfer_c;
    logic                pix_clr_c;
    logic                pix_adv_c;
    logic [ADDR_W-1:0]   addr_even_c;
    logic [ADDR_W-1:0]   addr_odd_c;
    logic                last_pair_c;

    dmd_pix_addr_gen #(
        .NPIX        (NPIX),
        .ADDR_W      (ADDR_W),
        .ADDR_STRIDE (ADDR_STRIDE)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .clr         (pix_clr_c),
        .adv         (pix_adv_c),
        .addr_even_c (addr_even_c),
        .addr_odd_c  (addr_odd_c),
        .last_pair_c (last_pair_c)
    );

    assign xfer_c = s_valid && s_ready_q;

    always_comb begin
        state_d   = state_q;
        wea_d     = 1'b0;
        addra_d   = addra_q;
        dina_d    = dina_q;
        nib_d     = nib_q;
        done_d    = 1'b0;
        pix_clr_c = 1'b0;
        pix_adv_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (xfer_c && (s_data == SYNC_BYTE)) begin
                    pix_clr_c = 1'b1;
                    state_d   = HI;
                end
            end
            HI: begin
                if (xfer_c) begin
                    nib_d   = s_data[3:0];
                    wea_d   = 1'b1;
                    dina_d  = s_data[7:4];
                    addra_d = addr_even_c;
                    state_d = LO;
                end
            end
            LO: begin
                wea_d     = 1'b1;
                dina_d    = nib_q;
                addra_d   = addr_odd_c;
                pix_adv_c = 1'b1;
                if (last_pair_c) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = HI;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Ready is withheld only while the latched odd nibble drains.
        s_ready_d = (state_d != LO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            s_ready_q <= 1'b0;
            wea_q     <= 1'b0;
            addra_q   <= '0;
            dina_q    <= '0;
            nib_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= s_ready_d;
            wea_q     <= wea_d;
            addra_q   <= addra_d;
            dina_q    <= dina_d;
            nib_q     <= nib_d;
            done_q    <= done_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign wea        = wea_q;
    assign addra      = addra_q;
    assign dina       = dina_q;
    assign frame_done = done_q;
    // The final write lands while the state is already IDLE, so it is folded in.
    assign busy       = (state_q != IDLE) || done_q;

endmodule

// File: tb/tb_dmd_frame_loader.sv
// Directed self-checking bench for dmd_frame_loader.
`timescale 1ns/1ps
module tb_dmd_frame_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        wea;
    logic [12:0] addra;
    logic [3:0]  dina;
    logic        busy;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;

    int          wr_addr[$];
    int          wr_data[$];
    int          wr_cyc[$];

    dmd_frame_loader dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .wea        (wea),
        .addra      (addra),
        .dina       (dina),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (wea) begin
            wr_addr.push_back(int'(addra));
            wr_data.push_back(int'(dina));
            wr_cyc.push_back(cyc);
        end
        if (frame_done) done_cnt++;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cnt = 0;
    endtask

    // Returns #1 after the accepting edge.
    task automatic send(input logic [7:0] b);
        int n;
        s_data  = b;
        s_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check_eq("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int bad_a;
        int bad_d;
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hA5;

        // Reset with s_valid held high
        #13;
        check_eq("rst_wea", int'(wea), 0);
        check_eq("rst_addra", int'(addra), 0);
        check_eq("rst_dina", int'(dina), 0);
        check_eq("rst_ready", int'(s_ready), 0);
        check_eq("rst_busy", int'(busy), 0);
        s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("idle_ready", int'(s_ready), 1);
        check_eq("idle_busy", int'(busy), 0);

        // IDLE filtering
        clear_log();
        send(8'h12);
        send(8'hFF);
        idle_cycles(2);
        check_eq("filter_nowr", wr_addr.size(), 0);
        check_eq("filter_busy", int'(busy), 0);
        send(8'hA5);
        check_eq("sync_busy", int'(busy), 1);
        check_eq("sync_nowr", wr_addr.size(), 0);

        // Basic unpack with cycle-exact checks
        send(8'h3C);
        check_eq("u1_wea", int'(wea), 1);
        check_eq("u1_addr", int'(addra), 0);
        check_eq("u1_data", int'(dina), 3);
        check_eq("u1_ready", int'(s_ready), 0);
        idle_cycles(1);
        check_eq("u2_wea", int'(wea), 1);
        check_eq("u2_addr", int'(addra), 4);
        check_eq("u2_data", int'(dina), 12);
        check_eq("u2_ready", int'(s_ready), 1);
        idle_cycles(1);
        check_eq("u3_wea", int'(wea), 0);
        check_eq("u3_addr_hold", int'(addra), 4);
        check_eq("u3_data_hold", int'(dina), 12);

        // Back-to-back with valid held high, then idle gaps
        do_reset();
        clear_log();
        send(8'hA5);
        send(8'h12);
        send(8'h34);
        idle_cycles(6);
        check_eq("bp_count", wr_addr.size(), 4);
        if (wr_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check_eq($sformatf("bp_addr%0d", i), wr_addr[i], 4 * i);
                check_eq($sformatf("bp_data%0d", i), wr_data[i], i + 1);
                check_eq($sformatf("bp_cyc%0d", i), wr_cyc[i] - wr_cyc[0], i);
            end
        end

        // Full frame of 0xA5 payload
        do_reset();
        clear_log();
        send(8'hA5);
        for (int i = 0; i < 1023; i++) send(8'hA5);
        send(8'hA5);
        check_eq("ff_pre_done", int'(frame_done), 0);
        idle_cycles(1);
        check_eq("ff_last_wea", int'(wea), 1);
        check_eq("ff_last_addr", int'(addra), 8188);
        check_eq("ff_last_done", int'(frame_done), 1);
        check_eq("ff_last_busy", int'(busy), 1);
        idle_cycles(1);
        check_eq("ff_after_done", int'(frame_done), 0);
        check_eq("ff_after_busy", int'(busy), 0);
        check_eq("ff_count", wr_addr.size(), 2048);
        check_eq("ff_done_cnt", done_cnt, 1);
        bad_a = 0;
        bad_d = 0;
        for (int i = 0; i < wr_addr.size(); i++) begin
            if (wr_addr[i] != 4 * i) bad_a++;
            if (wr_data[i] != ((i % 2 == 0) ? 10 : 5)) bad_d++;
        end
        check_eq("ff_bad_addr", bad_a, 0);
        check_eq("ff_bad_data", bad_d, 0);
        clear_log();
        send(8'hA5);
        send(8'h77);
        check_eq("ff_restart_addr", int'(addra), 0);
        check_eq("ff_restart_data", int'(dina), 7);

        // Reset mid-frame
        do_reset();
        clear_log();
        send(8'hA5);
        for (int i = 0; i < 100; i++) send(8'h5A);
        s_valid = 1'b1;
        s_data  = 8'hA5;
        rst     = 1'b1;
        #1;
        check_eq("mr_wea", int'(wea), 0);
        check_eq("mr_addra", int'(addra), 0);
        check_eq("mr_dina", int'(dina), 0);
        check_eq("mr_ready", int'(s_ready), 0);
        check_eq("mr_busy", int'(busy), 0);
        s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(3);
        check_eq("mr_no_done", done_cnt, 0);
        check_eq("mr_busy_idle", int'(busy), 0);
        send(8'hA5);
        send(8'h9B);
        check_eq("mr_new_addr", int'(addra), 0);
        check_eq("mr_new_data", int'(dina), 9);
        idle_cycles(1);
        check_eq("mr_new_addr2", int'(addra), 4);
        check_eq("mr_new_data2", int'(dina), 11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
